gcd_stein: RTL and testbench
============================

Name: gcd_stein

Overview:
- Parametrised successor of the team's FSMD GCD unit.
- Computes the GCD of two unsigned WIDTH-bit operands with the binary (Stein) algorithm: shift and subtract only, one datapath step per cycle.
- Operands arrive serially on one bus under the existing req/ack four-phase handshake.
- Sits behind a controller that issues one operand per handshake and reads the result on the second ack.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- KW, $clog2(WIDTH+1), width of the common-power-of-two counter k; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request; one four-phase handshake per operand.
- AB  in  WIDTH  operand bus; carries A, then B.
- ack  out  1  A captured (first handshake) / result valid (second handshake).
- C  out  WIDTH  result; 0 whenever ack is not asserted in DONE.
- busy  out  1  high from B capture until entry to DONE.

Behaviour:
- Reset (reset_n=0, any state, including mid-compute): state→WAIT_A; a, b, k, result cleared; ack=0, C=0, busy=0.
- ack, C and busy are decoded from registered state only; no combinational path from req or AB.
- States and transitions:
  - WAIT_A: req=1 → a<=AB, go ACK_A.
  - ACK_A: ack=1; stay while req=1; req=0 → WAIT_B.
  - WAIT_B: req=1 → b<=AB, k<=0, go CALC.
  - CALC: busy=1; one step per cycle, priority order:
    1. a==0 → result<=b<<k, go DONE.
    2. b==0 → result<=a<<k, go DONE.
    3. a, b both even → a>>=1, b>>=1, k++.
    4. only a even → a>>=1.
    5. only b even → b>>=1.
    6. both odd, a>=b → a<=(a-b)>>1.
    7. both odd, a<b → b<=(b-a)>>1.
  - DONE: ack=1, C=result; stay while req=1; req=0 → WAIT_A.
- req held high on entry to CALC is ignored; the next A capture requires req low in DONE, then high in WAIT_A.
- Arithmetic:
  - Subtraction is unsigned WIDTH-bit; the operand order guarantees no underflow.
  - k ≤ WIDTH-1; result fits in WIDTH bits because gcd ≤ max(A,B).
- Boundary cases:
  - gcd(0,0)=0; gcd(0,x)=x; gcd(x,0)=x; A==B returns A.
  - All-ones operands are legal.
- Latency:
  - B capture to DONE entry ≤ 2*WIDTH+1 cycles; each CALC step removes at least one bit from a or b.
  - Equal odd operands: 2 CALC cycles.
- AB is sampled only on the WAIT_A→ACK_A and WAIT_B→CALC edges; it is don't-care elsewhere.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles, width $clog2(2*WIDTH+2).
  - Counter clears on B capture and increments once per CALC cycle.
  - Value is frozen and valid while in DONE; 0 after reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic, WIDTH=16: A=48, B=18 → ack in DONE with C=6; busy deasserts on DONE entry; C=0 after req drops.
- Zero operands: (0,0) → C=0 after 1 CALC cycle; (0,35) → C=35; (35,0) → C=35.
- Powers of two: A=32768, B=49152 → C=16384 (k=14); (65535,65535) → C=65535 after exactly 2 CALC cycles.
- Handshake:
  - req held high 5 cycles in ACK_A → single A capture, ack high throughout, no B capture until req low then high.
  - Same check in DONE: no new A capture until req low.
- Reset mid-operation: reset_n pulsed low during CALC of (48,18) → immediately ack=0, C=0, busy=0, state WAIT_A; subsequent (21,14) → C=7.
- Random/bound: 1000 random pairs vs reference model; C matches; CALC cycle count ≤ 33 for WIDTH=16. With GCD_CYCLE_COUNT_EN defined, cycles output equals the measured count.

Source files
------------

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD over a serial four-phase req/ack operand bus.
// Define GCD_CYCLE_COUNT_EN to add the CALC cycle-count output "cycles".
module gcd_stein #(
    parameter int WIDTH = 16,
    localparam int KW = $clog2(WIDTH + 1)
`ifdef GCD_CYCLE_COUNT_EN
    ,localparam int CW = $clog2(2 * WIDTH + 2)
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic [WIDTH-1:0] AB,
    output logic             ack,
    output logic [WIDTH-1:0] C,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,output logic [CW-1:0]   cycles
`endif
);

    typedef enum logic [2:0] {
        WAIT_A,
        ACK_A,
        WAIT_B,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] b_minus_a;

    assign a_minus_b = a - b;
    assign b_minus_a = b - a;

    // C is zero outside DONE, so it only carries result there
    assign C = (state == DONE) ? result : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= WAIT_A;
            a      <= '0;
            b      <= '0;
            k      <= '0;
            result <= '0;
            ack    <= 1'b0;
            busy   <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
            cycles <= '0;
`endif
        end else begin
            case (state)
                WAIT_A: begin
                    if (req) begin
                        a     <= AB;
                        ack   <= 1'b1;
                        state <= ACK_A;
                    end
                end
                ACK_A: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (req) begin
                        b     <= AB;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
`ifdef GCD_CYCLE_COUNT_EN
                        cycles <= '0;
`endif
                    end
                end
                CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
                    cycles <= cycles + CW'(1);
`endif
                    if (a == '0) begin
                        result <= b << k;
                        busy   <= 1'b0;
                        ack    <= 1'b1;
                        state  <= DONE;
                    end else if (b == '0) begin
                        result <= a << k;
                        busy   <= 1'b0;
                        ack    <= 1'b1;
                        state  <= DONE;
                    end else if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + KW'(1);
                    end else if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a >= b) begin
                        a <= a_minus_b >> 1;
                    end else begin
                        b <= b_minus_a >> 1;
                    end
                end
                DONE: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= WAIT_A;
                    end
                end
                default: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed and random checks for gcd_stein over the req/ack operand bus.
// Build with GCD_CYCLE_COUNT_EN to also check the cycles output.
module tb_gcd_stein;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req = 1'b0;
    logic [W-1:0] AB = '0;
    logic         ack;
    logic [W-1:0] C;
    logic         busy;
`ifdef GCD_CYCLE_COUNT_EN
    logic [$clog2(2*W+2)-1:0] cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    gcd_stein #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .AB      (AB),
        .ack     (ack),
        .C       (C),
        .busy    (busy)
`ifdef GCD_CYCLE_COUNT_EN
        ,.cycles (cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        int           n;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic wait_ack(input logic lvl, input string nm);
        int i = 0;
        while (ack !== lvl && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 32'(ack), 32'(lvl));
    endtask

    task automatic send_a(input logic [W-1:0] a, input int hold);
        req = 1'b1;
        AB  = a;
        @(negedge clk);
        wait_ack(1'b1, "a_ack");
        for (int i = 0; i < hold; i++) begin
            AB = ~a;
            @(negedge clk);
            chk("hold_a_ack", 32'(ack), 32'd1);
            chk("hold_a_busy", 32'(busy), 32'd0);
        end
        req = 1'b0;
        AB  = W'($urandom);
        @(negedge clk);
        wait_ack(1'b0, "a_release");
    endtask

    task automatic send_b(input logic [W-1:0] b, output logic [W-1:0] c,
                          output int n);
        int g = 0;
        n   = 0;
        req = 1'b1;
        AB  = b;
        @(negedge clk);
        AB = W'($urandom);
        while (ack !== 1'b1 && g < 60) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
            g++;
        end
        chk("done_ack", 32'(ack), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        c = C;
    endtask

    task automatic release_done();
        req = 1'b0;
        @(negedge clk);
        chk("rel_ack", 32'(ack), 32'd0);
        chk("rel_c", 32'(C), 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expc, input int expn);
        logic [W-1:0] c;
        int n;
        send_a(a, 0);
        send_b(b, c, n);
        chk($sformatf("gcd(%0d,%0d)", a, b), 32'(c), 32'(expc));
        if (expn >= 0) chk("calc_cycles", 32'(n), 32'(expn));
        chk("calc_bound", 32'(n <= 2 * W + 1), 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
        chk("cycles_port", 32'(cycles), 32'(n));
`endif
        release_done();
    endtask

    initial begin
        logic [W-1:0] c, ra, rb;
        int n;

        tbl[0] = '{16'd48, 16'd18, 16'd6, 7};
        tbl[1] = '{16'd0, 16'd0, 16'd0, 1};
        tbl[2] = '{16'd0, 16'd35, 16'd35, 1};
        tbl[3] = '{16'd35, 16'd0, 16'd35, 1};
        tbl[4] = '{16'd32768, 16'd49152, 16'd16384, 18};
        tbl[5] = '{16'd65535, 16'd65535, 16'd65535, 2};
        tbl[6] = '{16'd21, 16'd14, 16'd7, 4};
        tbl[7] = '{16'd12, 16'd8, 16'd4, 6};
        tbl[8] = '{16'd1, 16'd1, 16'd1, 2};
        tbl[9] = '{16'd1, 16'd65535, 16'd1, -1};

        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_c", 32'(C), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("rst_cycles", 32'(cycles), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].n);

        // req held through ACK_A: A must not be re-captured
        send_a(16'd48, 5);
        send_b(16'd18, c, n);
        chk("hold_a_result", 32'(c), 32'd6);
        // req held through DONE: no new A capture, output stable
        AB = 16'd77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done_ack", 32'(ack), 32'd1);
            chk("hold_done_c", 32'(C), 32'd6);
        end
        release_done();
        do_op(16'd100, 16'd75, 16'd25, -1);

        // asynchronous reset in the middle of CALC
        send_a(16'd48, 0);
        req = 1'b1;
        AB  = 16'd18;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        req     = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_c", 32'(C), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(16'd21, 16'd14, 16'd7, 4);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ra << $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) rb = rb << $urandom_range(0, 12);
            if ($urandom_range(0, 31) == 0) ra = '0;
            if ($urandom_range(0, 31) == 0) rb = '0;
            do_op(ra, rb, gcd_ref(ra, rb), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
